fpu_ss_wb_arbiter: RTL

Writeback and retire sequencer for the FPU subsystem. Buffers FPnew results in a small FIFO and owns the single FP register-file write port, which it arbitrates between buffered FPU results and memory (load) results. Memory results always win because the memory result interface cannot be stalled. Also drives the X-interface result channel, one beat per FPU instruction, and the FPR-write/scoreboard-clear strobe used by the controller.

---
 rtl/fpu_ss_pkg.sv | 15 +
 rtl/fpu_ss_wb_fifo.sv | 65 ++++++
 rtl/fpu_ss_wb_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem.
// wb_entry_t is one buffered FPnew result waiting to retire.
package fpu_ss_pkg;

  localparam int unsigned FpuFlen = 32;

  typedef struct packed {
    logic [FpuFlen-1:0] result;
    logic [4:0]         status;
    logic [3:0]         id;
    logic [4:0]         rd;
    logic               rd_is_fp;
  } wb_entry_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Result FIFO for FPU writeback.
// No fall-through: a pushed entry is visible at the head one cycle later.
module fpu_ss_wb_fifo import fpu_ss_pkg::*; #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  wb_entry_t       data_i,
  input  logic            pop_i,
  output wb_entry_t       data_o,
  output logic            valid_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pointers wrap modulo Depth; count alone separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// FPU writeback/retire sequencer: buffers FPnew results and shares the single FPR
// write port with load results, which always win because they cannot be stalled.
module fpu_ss_wb_arbiter import fpu_ss_pkg::*; #(
  parameter int unsigned FLEN       = FpuFlen,
  parameter int unsigned DEPTH      = 2,
  parameter bit          PULP_ZFINX = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fpu_out_valid_i,
  output logic                       fpu_out_ready_o,
  input  logic [FLEN-1:0]            fpu_out_result_i,
  input  logic [4:0]                 fpu_out_status_i,
  input  logic [3:0]                 fpu_out_id_i,
  input  logic [4:0]                 fpu_out_rd_i,
  input  logic                       fpu_out_rd_is_fp_i,
  input  logic                       mem_result_valid_i,
  input  logic                       mem_result_we_i,
  input  logic [4:0]                 mem_result_rd_i,
  input  logic [FLEN-1:0]            mem_result_rdata_i,
  output logic                       fpr_we_o,
  output logic [4:0]                 fpr_waddr_o,
  output logic [FLEN-1:0]            fpr_wdata_o,
  output logic                       x_result_valid_o,
  input  logic                       x_result_ready_i,
  output logic [3:0]                 x_result_id_o,
  output logic [31:0]                x_result_data_o,
  output logic [4:0]                 x_result_rd_o,
  output logic                       x_result_we_o,
  output logic [4:0]                 x_result_fflags_o,
  output logic                       x_result_fflags_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  wb_entry_t push_entry;
  wb_entry_t head;
  logic      head_valid;
  logic      full;
  logic      push;
  logic      pop;
  logic      mem_wr;
  logic      fpr_conflict;
  logic      head_fp_wr;

  assign push_entry = '{
    result:   fpu_out_result_i,
    status:   fpu_out_status_i,
    id:       fpu_out_id_i,
    rd:       fpu_out_rd_i,
    rd_is_fp: fpu_out_rd_is_fp_i
  };

  // Ready comes from the registered count only, so it never depends on x_result_ready_i.
  assign fpu_out_ready_o = ~full;
  assign push            = fpu_out_valid_i & ~full;

  fpu_ss_wb_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (head_valid),
    .full_o  (full),
    .count_o (occupancy_o)
  );

  // Store responses (we=0) never claim the FPR port, so they never block the head.
  assign mem_wr       = mem_result_valid_i & mem_result_we_i & ~PULP_ZFINX;
  assign fpr_conflict = head.rd_is_fp & mem_wr;

  assign x_result_valid_o        = head_valid & ~fpr_conflict;
  assign x_result_fflags_valid_o = x_result_valid_o;
  assign pop                     = x_result_valid_o & x_result_ready_i;
  assign head_fp_wr              = pop & head.rd_is_fp & ~PULP_ZFINX;

  assign x_result_id_o     = head.id;
  assign x_result_rd_o     = head.rd;
  assign x_result_data_o   = head.result[31:0];
  assign x_result_fflags_o = head.status;
  assign x_result_we_o     = head_valid & (~head.rd_is_fp | PULP_ZFINX);

  always_comb begin
    fpr_we_o    = 1'b0;
    fpr_waddr_o = '0;
    fpr_wdata_o = '0;
    if (mem_wr) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = mem_result_rd_i;
      fpr_wdata_o = mem_result_rdata_i;
    end else if (head_fp_wr) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = head.rd;
      fpr_wdata_o = head.result;
    end
  end

endmodule
